// File: rtl/mhp_pkg.sv
// Shared types and constants for the MHP transmit arbiter.
// Holds the FSM encoding, frame phase lengths and field widths.
package mhp_pkg;

    localparam int ADDR_W  = 16;
    localparam int SIZE_W  = 16;
    localparam int BYTE_W  = 8;
    localparam int SUM_W   = 16;
    localparam int IDX_W   = 3;
    localparam int HDR_LEN = 7;
    localparam int SCS_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_SCS,
        ST_DONE
    } mhp_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src;
        logic [SIZE_W-1:0] size;
        logic [BYTE_W-1:0] dtype;
    } mhp_hdr_t;

    function automatic logic [BYTE_W-1:0] hdr_byte(
        input mhp_hdr_t         h,
        input logic [IDX_W-1:0] idx
    );
        logic [BYTE_W-1:0] b;
        case (idx)
            3'd0:    b = h.dst[15:8];
            3'd1:    b = h.dst[7:0];
            3'd2:    b = h.src[15:8];
            3'd3:    b = h.src[7:0];
            3'd4:    b = h.size[15:8];
            3'd5:    b = h.size[7:0];
            default: b = h.dtype;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mhp_scs_acc.sv
// 16-bit running byte sum used as the MHP frame check sequence.
// Clear wins over add when both are requested in one cycle.
module mhp_scs_acc
    import mhp_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [SUM_W-1:0]  sum_o
);

    logic [SUM_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = sum_q + {8'h00, byte_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mhp_tx_arb.sv
// Two-port round-robin MHP frame transmitter feeding a byte-wide
// valid/ready write port; emits header, payload and optional checksum.
module mhp_tx_arb
    import mhp_pkg::*;
#(
    parameter int SCS_EN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_dst0,
    input  logic [ADDR_W-1:0] i_dst1,
    input  logic [ADDR_W-1:0] i_src0,
    input  logic [ADDR_W-1:0] i_src1,
    input  logic [SIZE_W-1:0] i_size0,
    input  logic [SIZE_W-1:0] i_size1,
    input  logic [BYTE_W-1:0] i_dtype0,
    input  logic [BYTE_W-1:0] i_dtype1,
    input  logic [BYTE_W-1:0] i_pdata0,
    input  logic [BYTE_W-1:0] i_pdata1,
    output logic              o_pnext0,
    output logic              o_pnext1,
    output logic              o_grant0,
    output logic              o_grant1,
    output logic              o_done0,
    output logic              o_done1,
    output logic [BYTE_W-1:0] o_wdata,
    output logic              o_wvalid,
    input  logic              i_wready
);

    mhp_state_e        state_q, state_d;
    mhp_hdr_t          hdr_q, hdr_d, hdr_in;
    logic              sel_q, sel_d;
    logic              last_q, last_d;
    logic              fin_q, fin_d;
    logic              wvalid_q, wvalid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SIZE_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] wdata_q, wdata_d;
    logic [BYTE_W-1:0] pdata, acc_byte;
    logic [SUM_W-1:0]  sum;
    logic              win, ld, busy, pnext;
    logic              acc_clr, acc_add;

    // Port 1 wins only when it requests alone or port 0 was served last.
    assign win  = (i_req0 && i_req1) ? ~last_q : i_req1;
    assign ld   = !wvalid_q || i_wready;
    assign busy = (state_q == ST_HDR) || (state_q == ST_PAY) ||
                  (state_q == ST_SCS);

    assign hdr_in = win ? {i_dst1, i_src1, i_size1, i_dtype1}
                        : {i_dst0, i_src0, i_size0, i_dtype0};
    assign pdata  = sel_q ? i_pdata1 : i_pdata0;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        fin_d    = fin_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        pnext    = 1'b0;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        acc_byte = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_req0 || i_req1) begin
                    sel_d   = win;
                    hdr_d   = hdr_in;
                    cnt_d   = hdr_in.size;
                    idx_d   = '0;
                    fin_d   = 1'b0;
                    acc_clr = 1'b1;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (ld && !fin_q) begin
                    wdata_d  = hdr_byte(hdr_q, idx_q);
                    wvalid_d = 1'b1;
                    acc_add  = 1'b1;
                    acc_byte = hdr_byte(hdr_q, idx_q);
                    idx_d    = idx_q + 3'd1;
                    if (idx_q == IDX_W'(HDR_LEN - 1)) begin
                        idx_d = '0;
                        if (cnt_q != '0) begin
                            state_d = ST_PAY;
                        end else if (SCS_EN != 0) begin
                            state_d = ST_SCS;
                        end else begin
                            fin_d = 1'b1;
                        end
                    end
                end
            end
            ST_PAY: begin
                if (ld && !fin_q) begin
                    wdata_d  = pdata;
                    wvalid_d = 1'b1;
                    acc_add  = 1'b1;
                    acc_byte = pdata;
                    pnext    = 1'b1;
                    cnt_d    = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        if (SCS_EN != 0) begin
                            state_d = ST_SCS;
                        end else begin
                            fin_d = 1'b1;
                        end
                    end
                end
            end
            ST_SCS: begin
                if (ld && !fin_q) begin
                    wdata_d  = idx_q[0] ? sum[7:0] : sum[15:8];
                    wvalid_d = 1'b1;
                    idx_d    = idx_q + 3'd1;
                    if (idx_q == IDX_W'(SCS_LEN - 1)) begin
                        fin_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // The final byte has been handed over once it is accepted.
        if (busy && ld && fin_q) begin
            wvalid_d = 1'b0;
            fin_d    = 1'b0;
            state_d  = ST_DONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            hdr_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            fin_q    <= 1'b0;
            wdata_q  <= '0;
            wvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fin_q    <= fin_d;
            wdata_q  <= wdata_d;
            wvalid_q <= wvalid_d;
        end
    end

    mhp_scs_acc u_acc (
        .clk_i  (i_clk),
        .rst_ni (i_rst_n),
        .clr_i  (acc_clr),
        .add_i  (acc_add),
        .byte_i (acc_byte),
        .sum_o  (sum)
    );

    assign o_wdata  = wdata_q;
    assign o_wvalid = wvalid_q;
    assign o_grant0 = busy && !sel_q;
    assign o_grant1 = busy && sel_q;
    assign o_done0  = (state_q == ST_DONE) && !sel_q;
    assign o_done1  = (state_q == ST_DONE) && sel_q;
    assign o_pnext0 = pnext && !sel_q;
    assign o_pnext1 = pnext && sel_q;

endmodule

// File: tb/tb_mhp_tx_arb.sv
// Randomised self-checking bench for mhp_tx_arb against a frame-level
// byte model; a second instance covers the no-checksum build.
module tb_mhp_tx_arb;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req0 = 1'b0, i_req1 = 1'b0;
    logic [15:0] i_dst0 = '0, i_dst1 = '0, i_src0 = '0, i_src1 = '0;
    logic [15:0] i_size0 = '0, i_size1 = '0;
    logic [7:0]  i_dtype0 = '0, i_dtype1 = '0;
    logic [7:0]  i_pdata0, i_pdata1;
    logic        i_wready = 1'b1;

    logic        o_pnext0, o_pnext1, o_grant0, o_grant1, o_done0, o_done1;
    logic [7:0]  o_wdata;
    logic        o_wvalid;
    logic        z_pnext0, z_pnext1, z_grant0, z_grant1, z_done0, z_done1;
    logic [7:0]  z_wdata;
    logic        z_wvalid;

    int checks = 0;
    int failures = 0;

    logic [7:0] pay0 [512];
    logic [7:0] pay1 [512];
    logic [8:0] pidx0 = '0, pidx1 = '0;
    logic       adv0 = 1'b0, adv1 = 1'b0;
    int         wr_mode = 0;

    logic [7:0] q[$], qz[$], expq[$], expz[$];
    int dseq[$];
    int cyc = 0;
    int pn0, pn1, dn0, dn1, zdn0, zdn1;
    int stab_err, pn_err, g_first, v_first, done_cyc;
    logic       pv_stall;
    logic [7:0] pv_data;

    assign i_pdata0 = pay0[pidx0];
    assign i_pdata1 = pay1[pidx1];

    always #5 i_clk = ~i_clk;

    mhp_tx_arb #(.SCS_EN(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_dst0(i_dst0), .i_dst1(i_dst1),
        .i_src0(i_src0), .i_src1(i_src1),
        .i_size0(i_size0), .i_size1(i_size1),
        .i_dtype0(i_dtype0), .i_dtype1(i_dtype1),
        .i_pdata0(i_pdata0), .i_pdata1(i_pdata1),
        .o_pnext0(o_pnext0), .o_pnext1(o_pnext1),
        .o_grant0(o_grant0), .o_grant1(o_grant1),
        .o_done0(o_done0), .o_done1(o_done1),
        .o_wdata(o_wdata), .o_wvalid(o_wvalid),
        .i_wready(i_wready)
    );

    mhp_tx_arb #(.SCS_EN(0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req0(i_req0), .i_req1(i_req1),
        .i_dst0(i_dst0), .i_dst1(i_dst1),
        .i_src0(i_src0), .i_src1(i_src1),
        .i_size0(i_size0), .i_size1(i_size1),
        .i_dtype0(i_dtype0), .i_dtype1(i_dtype1),
        .i_pdata0(i_pdata0), .i_pdata1(i_pdata1),
        .o_pnext0(z_pnext0), .o_pnext1(z_pnext1),
        .o_grant0(z_grant0), .o_grant1(z_grant1),
        .o_done0(z_done0), .o_done1(z_done1),
        .o_wdata(z_wdata), .o_wvalid(z_wvalid),
        .i_wready(i_wready)
    );

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    // Observe everything mid-cycle, away from the active edge.
    initial forever begin
        @(negedge i_clk);
        if (o_wvalid && i_wready) q.push_back(o_wdata);
        if (z_wvalid && i_wready) qz.push_back(z_wdata);
        if (pv_stall && (!o_wvalid || o_wdata !== pv_data)) stab_err++;
        pv_stall = o_wvalid && !i_wready;
        pv_data  = o_wdata;
        adv0 = o_pnext0;
        adv1 = o_pnext1;
        if (o_pnext0) pn0++;
        if (o_pnext1) pn1++;
        if ((o_pnext0 && !o_grant0) || (o_pnext1 && !o_grant1)) pn_err++;
        if (o_done0) begin dn0++; done_cyc = cyc; dseq.push_back(0); end
        if (o_done1) begin dn1++; done_cyc = cyc; dseq.push_back(1); end
        if (z_done0) zdn0++;
        if (z_done1) zdn1++;
        if ((o_grant0 || o_grant1) && g_first < 0) g_first = cyc;
        if (o_wvalid && v_first < 0) v_first = cyc;
    end

    // Payload source and write-port ready pattern.
    initial forever begin
        @(posedge i_clk);
        #1;
        if (adv0) pidx0 = pidx0 + 9'd1;
        if (adv1) pidx1 = pidx1 + 9'd1;
        case (wr_mode)
            0:       i_wready = 1'b1;
            1:       i_wready = ~i_wready;
            default: i_wready = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic int first_diff(input logic [7:0] a[$],
                                      input logic [7:0] b[$]);
        int n;
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] at(input logic [7:0] a[$], input int i);
        if (i >= 0 && i < a.size()) return a[i];
        return 8'hxx;
    endfunction

    function automatic int cnt_of(input int sel);
        case (sel)
            0:       return dn0;
            1:       return dn1;
            2:       return zdn0;
            default: return zdn1;
        endcase
    endfunction

    task automatic clear_mon();
        q.delete(); qz.delete(); expq.delete(); expz.delete(); dseq.delete();
        pn0 = 0; pn1 = 0; dn0 = 0; dn1 = 0; zdn0 = 0; zdn1 = 0;
        stab_err = 0; pn_err = 0; g_first = -1; v_first = -1; done_cyc = -1;
        pv_stall = 1'b0; adv0 = 1'b0; adv1 = 1'b0;
        pidx0 = '0; pidx1 = '0;
    endtask

    task automatic do_reset();
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #1;
        clear_mon();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_pay();
        for (int i = 0; i < 512; i++) begin
            pay0[i] = 8'($urandom);
            pay1[i] = 8'($urandom);
        end
    endtask

    task automatic set_hdr(input bit p, input logic [15:0] d, s, sz,
                           input logic [7:0] t);
        if (p) begin
            i_dst1 = d; i_src1 = s; i_size1 = sz; i_dtype1 = t;
        end else begin
            i_dst0 = d; i_src0 = s; i_size0 = sz; i_dtype0 = t;
        end
    endtask

    // Expected wire bytes for one frame, computed from the frame format.
    task automatic exp_frame(input bit p, input bit scs,
                             input logic [15:0] d, s, sz,
                             input logic [7:0] t, input int off,
                             input bit toz);
        logic [7:0]  b[$];
        logic [15:0] sum;
        b = {d[15:8], d[7:0], s[15:8], s[7:0], sz[15:8], sz[7:0], t};
        for (int k = 0; k < int'(sz); k++)
            b.push_back(p ? pay1[9'((off + k) % 512)] : pay0[9'((off + k) % 512)]);
        sum = '0;
        foreach (b[i]) sum = sum + {8'h00, b[i]};
        if (scs) begin
            b.push_back(sum[15:8]);
            b.push_back(sum[7:0]);
        end
        foreach (b[i]) begin
            if (toz) expz.push_back(b[i]);
            else expq.push_back(b[i]);
        end
    endtask

    task automatic wait_done(input int sel, input int n, input int budget,
                             output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge i_clk);
            #1;
            if (cnt_of(sel) >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_req0 = 1'b1;
        i_req1 = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (o_wvalid !== 1'b0 || z_wvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_wvalid got=%b/%b exp=0", o_wvalid, z_wvalid);
        end
        checks++;
        if (o_wdata !== 8'h00) begin
            failures++;
            $display("FAIL rst_wdata got=%h exp=00", o_wdata);
        end
        checks++;
        if ({o_grant0, o_grant1, o_done0, o_done1, o_pnext0, o_pnext1} !== 6'b0) begin
            failures++;
            $display("FAIL rst_ctl got=%b exp=000000",
                     {o_grant0, o_grant1, o_done0, o_done1, o_pnext0, o_pnext1});
        end
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if ({o_grant0, o_grant1} !== 2'b10) begin
            failures++;
            $display("FAIL rst_first_winner got=%b exp=10", {o_grant0, o_grant1});
        end
        do_reset();
    endtask

    task automatic test_basic();
        bit ok;
        int t, fd;
        do_reset();
        wr_mode = 0;
        expq = {8'h12, 8'h34, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h83, 8'h01, 8'hC8};
        set_hdr(0, 16'h1234, 16'h00FF, 16'h0000, 8'h83);
        i_req0 = 1'b1;
        t = cyc;
        wait_done(0, 1, 100, ok);
        i_req0 = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout got=%0d exp=1 done pulses", dn0);
        end
        fd = first_diff(q, expq);
        checks++;
        if (fd != -1) begin
            failures++;
            $display("FAIL basic_bytes idx=%0d got=%h exp=%h n=%0d/%0d",
                     fd, at(q, fd), at(expq, fd), q.size(), expq.size());
        end
        checks++;
        if (g_first !== t + 1) begin
            failures++;
            $display("FAIL basic_grant_cyc got=%0d exp=%0d", g_first, t + 1);
        end
        checks++;
        if (v_first !== t + 2) begin
            failures++;
            $display("FAIL basic_first_valid got=%0d exp=%0d", v_first, t + 2);
        end
        checks++;
        if (done_cyc !== t + 11) begin
            failures++;
            $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, t + 11);
        end
        repeat (5) @(posedge i_clk);
        #1;
        checks++;
        if (dn0 !== 1 || dn1 !== 0) begin
            failures++;
            $display("FAIL basic_done_count got=%0d/%0d exp=1/0", dn0, dn1);
        end
    endtask

    task automatic test_both();
        bit ok;
        int fd;
        logic [15:0] d0, s0, d1, s1, sz0, sz1;
        logic [7:0]  t0, t1;
        do_reset();
        fill_pay();
        wr_mode = 2;
        d0 = 16'($urandom); s0 = 16'($urandom); t0 = 8'($urandom);
        d1 = 16'($urandom); s1 = 16'($urandom); t1 = 8'($urandom);
        sz0 = 16'($urandom_range(1, 6));
        sz1 = 16'($urandom_range(0, 6));
        set_hdr(0, d0, s0, sz0, t0);
        set_hdr(1, d1, s1, sz1, t1);
        exp_frame(0, 1, d0, s0, sz0, t0, 0, 0);
        exp_frame(1, 1, d1, s1, sz1, t1, 0, 0);
        exp_frame(0, 1, d0, s0, sz0, t0, int'(sz0), 0);
        i_req0 = 1'b1;
        i_req1 = 1'b1;
        wait_done(0, 1, 400, ok);
        checks++;
        if (!ok || dn1 !== 0) begin
            failures++;
            $display("FAIL both_first got=%0d/%0d exp=1/0", dn0, dn1);
        end
        wait_done(1, 1, 400, ok);
        wait_done(0, 2, 400, ok);
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        checks++;
        if (dseq.size() != 3 || dseq[0] != 0 || dseq[1] != 1 || dseq[2] != 0) begin
            failures++;
            $display("FAIL both_order got=%p exp=0,1,0", dseq);
        end
        fd = first_diff(q, expq);
        checks++;
        if (fd != -1) begin
            failures++;
            $display("FAIL both_bytes idx=%0d got=%h exp=%h n=%0d/%0d",
                     fd, at(q, fd), at(expq, fd), q.size(), expq.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        int fd, n;
        logic [15:0] d, s, hsum, got;
        logic [7:0]  t;
        do_reset();
        fill_pay();
        wr_mode = 1;
        pay1[0] = 8'hAA; pay1[1] = 8'hBB; pay1[2] = 8'hCC;
        d = 16'($urandom); s = 16'($urandom); t = 8'($urandom);
        set_hdr(1, d, s, 16'd3, t);
        exp_frame(1, 1, d, s, 16'd3, t, 0, 0);
        hsum = {8'h00, d[15:8]} + {8'h00, d[7:0]} + {8'h00, s[15:8]}
             + {8'h00, s[7:0]} + 16'h0003 + {8'h00, t};
        i_req1 = 1'b1;
        wait_done(1, 1, 200, ok);
        i_req1 = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_timeout got=%0d exp=1 done pulses", dn1);
        end
        fd = first_diff(q, expq);
        checks++;
        if (fd != -1) begin
            failures++;
            $display("FAIL stall_bytes idx=%0d got=%h exp=%h n=%0d/%0d",
                     fd, at(q, fd), at(expq, fd), q.size(), expq.size());
        end
        n = q.size();
        got = {at(q, n - 2), at(q, n - 1)};
        checks++;
        if (got !== hsum + 16'h0231) begin
            failures++;
            $display("FAIL stall_scs got=%h exp=%h", got, hsum + 16'h0231);
        end
        checks++;
        if (pn1 !== 3 || pn0 !== 0) begin
            failures++;
            $display("FAIL stall_pnext got=%0d/%0d exp=0/3", pn0, pn1);
        end
        checks++;
        if (stab_err !== 0 || pn_err !== 0) begin
            failures++;
            $display("FAIL stall_stable got=%0d/%0d exp=0/0", stab_err, pn_err);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int fd;
        logic [15:0] d, s;
        logic [7:0]  t;
        do_reset();
        fill_pay();
        wr_mode = 0;
        d = 16'($urandom); s = 16'($urandom); t = 8'($urandom);
        set_hdr(0, d, s, 16'd40, t);
        i_req0 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge i_clk);
            #1;
            if (pn0 >= 5) break;
        end
        checks++;
        if (pn0 < 5 || !o_grant0 || !o_wvalid) begin
            failures++;
            $display("FAIL rmid_in_pay got=%0d/%b/%b exp=5/1/1", pn0, o_grant0, o_wvalid);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_wvalid, o_grant0, o_wdata} !== 10'b0) begin
            failures++;
            $display("FAIL rmid_async got=%b/%b/%h exp=0/0/00", o_wvalid, o_grant0, o_wdata);
        end
        @(negedge i_clk);
        #1;
        clear_mon();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        exp_frame(0, 1, d, s, 16'd40, t, 0, 0);
        wait_done(0, 1, 200, ok);
        i_req0 = 1'b0;
        fd = first_diff(q, expq);
        checks++;
        if (!ok || fd != -1) begin
            failures++;
            $display("FAIL rmid_restart idx=%0d got=%h exp=%h ok=%b",
                     fd, at(q, fd), at(expq, fd), ok);
        end
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (dn0 !== 1) begin
            failures++;
            $display("FAIL rmid_done_count got=%0d exp=1", dn0);
        end
    endtask

    task automatic test_drop_req();
        bit ok;
        int fd;
        logic [15:0] d, s, sz;
        logic [7:0]  t;
        do_reset();
        fill_pay();
        wr_mode = 2;
        d = 16'($urandom); s = 16'($urandom); t = 8'($urandom);
        sz = 16'($urandom_range(1, 10));
        set_hdr(0, d, s, sz, t);
        exp_frame(0, 1, d, s, sz, t, 0, 0);
        i_req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge i_clk);
            #1;
            if (o_grant0) break;
        end
        i_req0 = 1'b0;
        set_hdr(0, 16'($urandom), 16'($urandom), 16'($urandom_range(1, 9)), 8'($urandom));
        wait_done(0, 1, 400, ok);
        repeat (4) @(posedge i_clk);
        #1;
        fd = first_diff(q, expq);
        checks++;
        if (!ok || fd != -1) begin
            failures++;
            $display("FAIL drop_bytes idx=%0d got=%h exp=%h n=%0d/%0d",
                     fd, at(q, fd), at(expq, fd), q.size(), expq.size());
        end
        checks++;
        if (dn0 !== 1) begin
            failures++;
            $display("FAIL drop_done_count got=%0d exp=1", dn0);
        end
    endtask

    task automatic test_no_scs();
        bit ok;
        int fd;
        logic [15:0] d, s, sz;
        logic [7:0]  t;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            fill_pay();
            wr_mode = 1;
            d = 16'($urandom); s = 16'($urandom); t = 8'($urandom);
            sz = (r == 0) ? 16'd0 : 16'($urandom_range(1, 8));
            set_hdr(1, d, s, sz, t);
            exp_frame(1, 0, d, s, sz, t, 0, 1);
            i_req1 = 1'b1;
            wait_done(3, 1, 200, ok);
            i_req1 = 1'b0;
            fd = first_diff(qz, expz);
            checks++;
            if (!ok || fd != -1) begin
                failures++;
                $display("FAIL noscs_bytes r=%0d idx=%0d got=%h exp=%h n=%0d/%0d",
                         r, fd, at(qz, fd), at(expz, fd), qz.size(), expz.size());
            end
            checks++;
            if (qz.size() != 7 + int'(sz) || zdn1 !== 1) begin
                failures++;
                $display("FAIL noscs_len r=%0d got=%0d/%0d exp=%0d/1",
                         r, qz.size(), zdn1, 7 + int'(sz));
            end
        end
    endtask

    task automatic test_random();
        bit ok, p;
        int fd;
        logic [15:0] d, s, sz;
        logic [7:0]  t;
        for (int r = 0; r < 7; r++) begin
            do_reset();
            fill_pay();
            p = 1'($urandom);
            wr_mode = (r == 6) ? 0 : 2;
            sz = (r == 6) ? 16'd300 : 16'($urandom_range(0, 20));
            d = 16'($urandom); s = 16'($urandom); t = 8'($urandom);
            set_hdr(p, d, s, sz, t);
            exp_frame(p, 1, d, s, sz, t, 0, 0);
            if (p) i_req1 = 1'b1;
            else i_req0 = 1'b1;
            wait_done(p ? 1 : 0, 1, (int'(sz) + 12) * 20 + 50, ok);
            i_req0 = 1'b0;
            i_req1 = 1'b0;
            fd = first_diff(q, expq);
            checks++;
            if (!ok || fd != -1) begin
                failures++;
                $display("FAIL rand_bytes r=%0d idx=%0d got=%h exp=%h n=%0d/%0d",
                         r, fd, at(q, fd), at(expq, fd), q.size(), expq.size());
            end
            checks++;
            if ((p ? pn1 : pn0) !== int'(sz) || stab_err !== 0 || pn_err !== 0) begin
                failures++;
                $display("FAIL rand_pnext r=%0d got=%0d/%0d/%0d exp=%0d/0/0",
                         r, p ? pn1 : pn0, stab_err, pn_err, sz);
            end
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_basic();
        test_both();
        test_stall();
        test_reset_mid();
        test_drop_req();
        test_no_scs();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mhp_tx_arb.md
MHP_TX_ARB -- requirements
Module: mhp_tx_arb

Interface
REQ-001 SHALL have parameter SCS_EN, default 1, meaning: 1 = append 2-byte SCS checksum, 0 = omit the SCS phase.
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports i_req0 / i_req1  input  1  frame request, level, per requester.
REQ-005 SHALL have ports i_dst0 / i_dst1, i_src0 / i_src1 and i_size0 / i_size1, each input 16 bits: MHP header fields.
REQ-006 SHALL have ports i_dtype0 / i_dtype1  input  8  MHP type byte.
REQ-007 SHALL have ports i_pdata0 / i_pdata1  input  8  current payload byte.
REQ-008 SHALL have ports o_pnext0 / o_pnext1  output  1  one-cycle pulse: current payload byte consumed, present the next byte the following cycle.
REQ-009 SHALL have ports o_grant0 / o_grant1  output  1  level, high while that requester's frame is in progress.
REQ-010 SHALL have ports o_done0 / o_done1  output  1  one-cycle pulse on frame completion.
REQ-011 SHALL have port o_wdata  output  8  byte to the eth write port.
REQ-012 SHALL have port o_wvalid  output  1  o_wdata valid.
REQ-013 SHALL have port i_wready  input  1  eth write port accepts a byte.

Function
REQ-014 Byte transfer SHALL occur in any cycle where o_wvalid and i_wready are both high; o_wdata and o_wvalid SHALL be registered and held stable while o_wvalid=1 and i_wready=0.
REQ-015 The output register SHALL load a new byte when o_wvalid=0 or i_wready=1, giving 1 byte/cycle sustained throughput.
REQ-016 Frame byte order SHALL be: dst[15:8], dst[7:0], src[15:8], src[7:0], size[15:8], size[7:0], dtype, size payload bytes, then scs[15:8], scs[7:0] if SCS_EN=1.
REQ-017 States SHALL be IDLE, HDR, PAY, SCS and DONE.
REQ-018 IDLE with any request at cycle T SHALL select a winner, latch its dst/src/size/dtype, and enter HDR with o_grantN=1 at T+1; the first byte SHALL be valid at T+2.
REQ-019 Arbitration SHALL be round-robin with a last-served pointer; when both requests are active, the requester not served last wins; after reset, port 0 wins.
REQ-020 HDR SHALL load 7 bytes under a 3-bit index; it SHALL then go to PAY if latched size != 0, else to SCS (SCS_EN=1) or DONE (SCS_EN=0).
REQ-021 PAY SHALL sample i_pdataN into the output register, pulse o_pnextN in that same cycle, and count with a 16-bit down-counter; size=0xFFFF SHALL be legal.
REQ-022 The checksum SHALL be the 16-bit modulo-2^16 sum of all header and payload bytes, accumulated as each byte is loaded.
REQ-023 SCS SHALL load the high then the low checksum byte.
REQ-024 DONE SHALL be entered when the last byte is accepted; in DONE: o_doneN=1 for one cycle, o_grantN=0, pointer updated, next state IDLE.
REQ-025 A new arbitration SHALL occur no earlier than the cycle after DONE.
REQ-026 Deassertion of i_reqN mid-frame SHALL be ignored; the frame SHALL complete.
REQ-027 Changes on the header inputs after the latch cycle SHALL have no effect.
REQ-028 o_wvalid SHALL be 0 whenever no unaccepted byte is held.
REQ-029 o_pnextN SHALL never pulse for the non-granted port.

Reset
REQ-030 On i_rst_n=0, immediately and asynchronously: state=IDLE, o_wvalid=0, o_wdata=0x00, o_grant0/1=0, o_done0/1=0, o_pnext0/1=0, checksum=0, counters=0, pointer set so port 0 wins next.
REQ-031 Reset mid-frame SHALL abandon the frame; no o_done pulse SHALL be produced for it.
REQ-032 After reset release, the block SHALL start in IDLE; the first frame SHALL begin at dst[15:8].

Structure
REQ-033 A shared package mhp_pkg SHALL hold the state encoding, the header length constant (7), the SCS length constant (2) and the field widths.
REQ-034 One sub-module, mhp_scs_acc (16-bit clear/add-byte accumulator), SHALL be used.

Verification
REQ-035 Port 0 request, dst=0x1234, src=0x00FF, size=0, dtype=0x83, i_wready=1 -> bytes 12 34 00 FF 00 00 83 01 C8 on 9 consecutive cycles, then o_done0 one pulse.
REQ-036 Both ports requesting from reset -> full port 0 frame, then port 1 frame; both held again -> port 0 wins.
REQ-037 Port 1, size=3, payload AA BB CC, i_wready toggling 1/0 -> o_wdata stable during stalls, exactly 3 o_pnext1 pulses, SCS = header sum + 0x0231.
REQ-038 i_rst_n low during PAY -> o_wvalid and o_grant drop immediately; the next request restarts at dst[15:8] with no o_done pulse.
REQ-039 SCS_EN=0, size=0 -> exactly 7 bytes, then o_done.
REQ-040 i_req0 dropped after the grant cycle -> the frame still completes with a correct checksum.
